// File: rtl/led_pattern_sched.sv
// led_pattern_sched
// Run/pause/stop sequencer for the 8-LED bank. Steps a pattern (rotate left,
// rotate right, ping-pong, bar-fill) once every eff_period cycles while
// running. Mode and step period are reprogrammed through a valid/ready
// config port that is only open while the bank is not running.
//
// Ports:
//   clk50m     - system clock
//   rst        - synchronous reset, active-high
//   start      - pulse: IDLE->RUN (load initial pattern) or PAUSE->RUN (resume)
//   pause      - pulse: RUN->PAUSE
//   stop       - pulse: any state->IDLE
//   cfg_valid  - config request
//   cfg_mode   - 0 shl, 1 shr, 2 ping-pong, 3 bar-fill
//   cfg_period - step period in cycles (0 behaves as 1)
//   cfg_ready  - registered, high in IDLE and PAUSE
//   led        - registered LED drive, 1 = on
//   step_pulse - high in the first cycle a stepped pattern shows on led
//   state_o    - 0 IDLE, 1 RUN, 2 PAUSE
module led_pattern_sched #(
   parameter int STEP_CYCLES = 10_000_000,
   parameter int CNT_W       = 30
) (
   input  logic             clk50m,
   input  logic             rst,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   input  logic             cfg_valid,
   input  logic [1:0]       cfg_mode,
   input  logic [CNT_W-1:0] cfg_period,
   output logic             cfg_ready,
   output logic [7:0]       led,
   output logic             step_pulse,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       led_d;
   logic             pulse_d;
   logic             ready_d;
   logic [1:0]       mode_q, mode_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_up_q, dir_up_d;

   logic             xfer;
   logic [CNT_W-1:0] last_cnt;
   logic [7:0]       init_pat;
   logic [7:0]       nxt_pat;
   logic             nxt_dir;

   assign xfer     = cfg_valid && cfg_ready;
   assign last_cnt = (period_q == '0) ? '0 : period_q - CNT_W'(1);

   // Initial pattern is taken from the mode that will be in effect after this
   // edge, so a config accepted in the same cycle as start/resume applies.
   always_comb begin
      init_pat = 8'h01;
      if (mode_d == 2'd1) init_pat = 8'h80;
   end

   always_comb begin
      nxt_pat = led;
      nxt_dir = dir_up_q;
      case (mode_q)
         2'd0: nxt_pat = {led[6:0], led[7]};
         2'd1: nxt_pat = {led[0], led[7:1]};
         2'd2: begin
            // Direction flips on arrival at an end so the end value is not repeated.
            if (dir_up_q) begin
               nxt_pat = {led[6:0], 1'b0};
               if (nxt_pat == 8'h80) nxt_dir = 1'b0;
            end else begin
               nxt_pat = {1'b0, led[7:1]};
               if (nxt_pat == 8'h01) nxt_dir = 1'b1;
            end
         end
         default: nxt_pat = (led == 8'hFF) ? 8'h00 : {led[6:0], 1'b1};
      endcase
   end

   always_comb begin
      state_d  = state_q;
      led_d    = led;
      pulse_d  = 1'b0;
      mode_d   = xfer ? cfg_mode : mode_q;
      period_d = xfer ? cfg_period : period_q;
      cnt_d    = xfer ? '0 : cnt_q;
      dir_up_d = dir_up_q;

      if (stop) begin
         state_d  = IDLE;
         led_d    = 8'h00;
         cnt_d    = '0;
         dir_up_d = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (pause) begin
                  state_d = PAUSE;
               end else if (cnt_q == last_cnt) begin
                  cnt_d    = '0;
                  led_d    = nxt_pat;
                  dir_up_d = nxt_dir;
                  pulse_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            PAUSE: begin
               if (xfer) begin
                  led_d    = init_pat;
                  dir_up_d = 1'b1;
               end
               if (start) state_d = RUN;
            end
            IDLE: begin
               if (start) begin
                  state_d  = RUN;
                  led_d    = init_pat;
                  cnt_d    = '0;
                  dir_up_d = 1'b1;
               end
            end
            default: begin
               state_d  = IDLE;
               led_d    = 8'h00;
               cnt_d    = '0;
               dir_up_d = 1'b1;
            end
         endcase
      end

      ready_d = (state_d != RUN);
   end

   always_ff @(posedge clk50m) begin
      if (rst) begin
         state_q    <= IDLE;
         led        <= 8'h00;
         step_pulse <= 1'b0;
         cfg_ready  <= 1'b1;
         mode_q     <= 2'd0;
         period_q   <= CNT_W'(STEP_CYCLES);
         cnt_q      <= '0;
         dir_up_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         led        <= led_d;
         step_pulse <= pulse_d;
         cfg_ready  <= ready_d;
         mode_q     <= mode_d;
         period_q   <= period_d;
         cnt_q      <= cnt_d;
         dir_up_q   <= dir_up_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Directed testbench for led_pattern_sched. Inputs change 1 ns after each
// rising edge; outputs are sampled at the same point, so every tick() shows
// the result of exactly one edge.
module tb_led_pattern_sched;

   localparam int CNT_W = 30;
   localparam int STEP  = 5;

   logic             clk50m = 1'b0;
   logic             rst, start, pause, stop, cfg_valid;
   logic [1:0]       cfg_mode;
   logic [CNT_W-1:0] cfg_period;
   logic             cfg_ready;
   logic [7:0]       led;
   logic             step_pulse;
   logic [1:0]       state_o;

   int n_checks = 0;
   int n_fail   = 0;

   led_pattern_sched #(.STEP_CYCLES(STEP), .CNT_W(CNT_W)) dut (
      .clk50m(clk50m), .rst(rst), .start(start), .pause(pause), .stop(stop),
      .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
      .cfg_ready(cfg_ready), .led(led), .step_pulse(step_pulse), .state_o(state_o)
   );

   always #10 clk50m = ~clk50m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk50m);
         #1;
      end
   endtask

   // One-edge pulse on the selected controls, then release them.
   task automatic ctl(input logic s, input logic p, input logic t);
      start = s; pause = p; stop = t;
      tick(1);
      start = 1'b0; pause = 1'b0; stop = 1'b0;
   endtask

   task automatic cfg(input logic [1:0] m, input logic [CNT_W-1:0] per);
      cfg_valid = 1'b1; cfg_mode = m; cfg_period = per;
      tick(1);
      cfg_valid = 1'b0;
   endtask

   logic [7:0] pp_seq [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
   logic [7:0] bar_seq [9] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};
   logic [7:0] shr_seq [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};

   initial begin
      rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
      cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_period = '0;
      tick(2);
      rst = 1'b0;
      check("rst_led", led, 8'h00);
      check("rst_state", state_o, 2'd0);
      check("rst_ready", cfg_ready, 1'b1);
      check("rst_pulse", step_pulse, 1'b0);

      // Default period after reset, mode 0
      ctl(1, 0, 0);
      check("def_led0", led, 8'h01);
      check("def_state", state_o, 2'd1);
      check("def_ready", cfg_ready, 1'b0);
      tick(STEP - 1);
      check("def_hold", led, 8'h01);
      check("def_hold_pulse", step_pulse, 1'b0);
      tick(1);
      check("def_step", led, 8'h02);
      check("def_step_pulse", step_pulse, 1'b1);

      // Reset during RUN
      rst = 1'b1;
      tick(1);
      check("rrun_led", led, 8'h00);
      check("rrun_state", state_o, 2'd0);
      check("rrun_ready", cfg_ready, 1'b1);
      check("rrun_pulse", step_pulse, 1'b0);
      tick(1);
      rst = 1'b0;

      // Mode 0, period 4, full wrap
      cfg(2'd0, 4);
      ctl(1, 0, 0);
      check("m0_led0", led, 8'h01);
      for (int i = 1; i <= 8; i++) begin
         tick(1);
         check("m0_mid_pulse", step_pulse, 1'b0);
         tick(2);
         check("m0_mid_led", led, 8'h01 << (i - 1));
         tick(1);
         check("m0_step", led, (i == 8) ? 8'h01 : (8'h01 << i));
         check("m0_step_pulse", step_pulse, 1'b1);
      end

      // Ping-pong, period 1
      ctl(0, 0, 1);
      check("stop_led", led, 8'h00);
      cfg(2'd2, 1);
      ctl(1, 0, 0);
      check("pp_led0", led, 8'h01);
      for (int i = 0; i < 16; i++) begin
         tick(1);
         check("pp_led", led, pp_seq[i]);
         check("pp_pulse", step_pulse, 1'b1);
      end

      // Pause / resume, mode 3, period 10
      ctl(0, 0, 1);
      cfg(2'd3, 10);
      ctl(1, 0, 0);
      check("pr_led0", led, 8'h01);
      tick(10);
      check("pr_step1", led, 8'h03);
      check("pr_step1_pulse", step_pulse, 1'b1);
      tick(3);
      ctl(0, 1, 0);
      check("pr_state_pause", state_o, 2'd2);
      check("pr_ready_pause", cfg_ready, 1'b1);
      for (int i = 0; i < 50; i++) begin
         tick(1);
         check("pr_frozen", led, 8'h03);
      end
      ctl(1, 0, 0);
      check("pr_state_run", state_o, 2'd1);
      tick(6);
      check("pr_not_yet", led, 8'h03);
      tick(1);
      check("pr_resume_step", led, 8'h07);
      check("pr_resume_pulse", step_pulse, 1'b1);

      // Handshake held through RUN, transfer once paused
      cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_period = 3;
      tick(2);
      check("hs_ready_run", cfg_ready, 1'b0);
      check("hs_led_run", led, 8'h07);
      ctl(0, 1, 0);
      check("hs_state_p", state_o, 2'd2);
      check("hs_led_p", led, 8'h07);
      tick(1);
      cfg_valid = 1'b0;
      check("hs_xfer_led", led, 8'h80);
      check("hs_xfer_state", state_o, 2'd2);
      check("hs_xfer_ready", cfg_ready, 1'b1);
      ctl(1, 0, 0);
      tick(2);
      check("hs_per_hold", led, 8'h80);
      tick(1);
      check("hs_per_step", led, 8'h40);

      // Priority: stop wins over pause and start
      ctl(1, 1, 1);
      check("pri_state", state_o, 2'd0);
      check("pri_led", led, 8'h00);
      check("pri_ready", cfg_ready, 1'b1);

      // Config + start in IDLE, period 0 steps every cycle
      cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_period = '0;
      ctl(1, 0, 0);
      cfg_valid = 1'b0;
      check("p0_led0", led, 8'h01);
      tick(1);
      check("p0_s1", led, 8'h02);
      tick(1);
      check("p0_s2", led, 8'h04);
      check("p0_pulse", step_pulse, 1'b1);

      // Config + stop in PAUSE: config latched, ends in IDLE
      ctl(0, 1, 0);
      cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_period = 2;
      ctl(0, 0, 1);
      cfg_valid = 1'b0;
      check("cs_state", state_o, 2'd0);
      check("cs_led", led, 8'h00);
      ctl(1, 0, 0);
      tick(1);
      check("cs_hold", led, 8'h01);
      tick(1);
      check("cs_mode3", led, 8'h03);

      // Bar-fill wrap with period 1
      ctl(0, 0, 1);
      cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_period = 1;
      ctl(1, 0, 0);
      cfg_valid = 1'b0;
      check("bar_led0", led, 8'h01);
      for (int i = 0; i < 9; i++) begin
         tick(1);
         check("bar_led", led, bar_seq[i]);
      end

      // Config + start in PAUSE: new pattern, mode 1 wrap
      ctl(0, 1, 0);
      cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_period = 1;
      ctl(1, 0, 0);
      cfg_valid = 1'b0;
      check("ps_state", state_o, 2'd1);
      check("ps_led0", led, 8'h80);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("shr_led", led, shr_seq[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
